// File: rtl/stack_seq.sv
// stack_seq: three-phase command sequencer driving a head-register stack with depth tracking and sticky error flags
module stack_seq #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        stk_we,
  output logic [1:0]  stk_delta,
  output logic [15:0] stk_wd,
  input  logic [15:0] stk_rd,
  output logic [4:0]  depth,
  output logic        ovf,
  output logic        unf,
  input  logic        err_clr
);
  localparam logic [4:0] CAP = 5'(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e      state_q;
  logic [4:0]  depth_q, depth_d;
  logic        ovf_q, unf_q, ovf_p_q, unf_p_q;
  logic        rsp_valid_q, rsp_err_q, we_q, we_d;
  logic [15:0] rsp_data_q, wd_q, wd_d;
  logic [1:0]  delta_q, delta_d;
  logic        ovf_hit, unf_hit, ok;
  // classify the offered command against current occupancy and precompute its stack strobe
  always_comb begin
    ovf_hit = cmd_op[0] == cmd_op[1] && depth_q == CAP;
    unf_hit = cmd_op != 2'b00 && depth_q == 5'd0;
    ok      = !ovf_hit && !unf_hit;
    we_d    = ok && cmd_op != 2'b01;
    delta_d = !ok ? 2'b00 : cmd_op == 2'b01 ? 2'b11 : cmd_op == 2'b10 ? 2'b00 : 2'b01;
    wd_d    = !we_d ? 16'h0 : cmd_op == 2'b11 ? stk_rd : cmd_data;
    depth_d = delta_q == 2'b01 ? depth_q + 5'd1 : delta_q == 2'b11 ? depth_q - 5'd1 : depth_q;
  end
  // IDLE accepts, EXEC strobes the stack and samples the old top, RESP holds until consumed
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q     <= IDLE;
      depth_q     <= 5'd0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ovf_p_q     <= 1'b0;
      unf_p_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 16'h0;
      we_q        <= 1'b0;
      delta_q     <= 2'b00;
      wd_q        <= 16'h0;
    end else begin
      ovf_q <= (state_q == EXEC && ovf_p_q) || (ovf_q && !err_clr);
      unf_q <= (state_q == EXEC && unf_p_q) || (unf_q && !err_clr);
      case (state_q)
        IDLE: if (cmd_valid) begin
          state_q <= EXEC;
          we_q    <= we_d;
          delta_q <= delta_d;
          wd_q    <= wd_d;
          ovf_p_q <= ovf_hit;
          unf_p_q <= unf_hit;
        end
        EXEC: begin
          state_q     <= RESP;
          we_q        <= 1'b0;
          delta_q     <= 2'b00;
          wd_q        <= 16'h0;
          depth_q     <= depth_d;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= stk_rd;
          rsp_err_q   <= ovf_p_q || unf_p_q;
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stk_we    = we_q && resetq;
  assign stk_delta = resetq ? delta_q : 2'b00;
  assign stk_wd    = wd_q;
  assign depth     = depth_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: directed scoreboard bench for stack_seq with a behavioural stack attached
module tb_stack_seq;
  logic        clk = 1'b0, resetq = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b1, err_clr = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'h0;
  logic        cmd_ready, rsp_valid, rsp_err, stk_we, ovf, unf;
  logic [15:0] rsp_data, stk_wd, stk_rd;
  logic [1:0]  stk_delta;
  logic [4:0]  depth;
  logic [15:0] mem [0:31];
  int          sp = 0;
  int          checks = 0, errors = 0, strobes = 0, s0 = 0;
  typedef struct {logic [15:0] d; logic e; logic [4:0] dep;} exp_t;
  exp_t        sb [$];
  exp_t        got;

  stack_seq #(.DEPTH(16)) dut (
    .clk(clk), .resetq(resetq), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .stk_we(stk_we), .stk_delta(stk_delta),
    .stk_wd(stk_wd), .stk_rd(stk_rd), .depth(depth), .ovf(ovf), .unf(unf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  assign stk_rd = sp == 0 ? 16'h0 : mem[sp-1];

  always @(posedge clk) begin
    if (!resetq) sp <= 0;
    else if (stk_delta == 2'b01) begin
      mem[sp] <= stk_wd;
      sp <= sp + 1;
    end else if (stk_delta == 2'b11 && sp > 0) sp <= sp - 1;
    else if (stk_we && sp > 0) mem[sp-1] <= stk_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stk_we || stk_delta != 2'b00) strobes++;
    if (resetq && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got data %0h want no response", rsp_data);
      end else begin
        got = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(got.d));
        chk("rsp_err", 32'(rsp_err), 32'(got.e));
        chk("depth", 32'(depth), 32'(got.dep));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [15:0] ed,
                       input logic ee, input logic [4:0] edep, input logic clr = 1'b0,
                       input bit wait_done = 1'b1);
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    sb.push_back('{ed, ee, edep});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    err_clr = clr;
    @(posedge clk);
    #1 err_clr = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic clear_errs();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_we", 32'(stk_we), 32'd0);
    chk("rst_delta", 32'(stk_delta), 32'd0);
    chk("rst_wd", 32'(stk_wd), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    resetq = 1'b1;
    issue(2'b00, 16'h1234, 16'h0000, 1'b0, 5'd1);
    issue(2'b00, 16'hBEEF, 16'h1234, 1'b0, 5'd2);
    issue(2'b01, 16'h0000, 16'hBEEF, 1'b0, 5'd1);
    issue(2'b01, 16'h0000, 16'h1234, 1'b0, 5'd0);
    s0 = strobes;
    issue(2'b01, 16'h0000, 16'h0000, 1'b1, 5'd0);
    chk("unf_set", 32'(unf), 32'd1);
    chk("ovf_clean", 32'(ovf), 32'd0);
    chk("unf_no_strobe", 32'(strobes), 32'(s0));
    clear_errs();
    chk("unf_clr", 32'(unf), 32'd0);
    issue(2'b10, 16'h9999, 16'h0000, 1'b1, 5'd0);
    issue(2'b11, 16'h0000, 16'h0000, 1'b1, 5'd0);
    chk("unf_rep_dup", 32'(unf), 32'd1);
    chk("unf_rep_dup_no_strobe", 32'(strobes), 32'(s0));
    clear_errs();
    for (int i = 1; i <= 17; i++) issue(2'b00, 16'(i), 16'(i - 1), 1'b0, 5'(i));
    s0 = strobes;
    issue(2'b00, 16'h0012, 16'h0011, 1'b1, 5'd17);
    chk("ovf_set", 32'(ovf), 32'd1);
    clear_errs();
    chk("ovf_clr", 32'(ovf), 32'd0);
    issue(2'b11, 16'h0000, 16'h0011, 1'b1, 5'd17, 1'b1);
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    chk("ovf_no_strobe", 32'(strobes), 32'(s0));
    clear_errs();
    for (int j = 0; j < 17; j++) issue(2'b01, 16'h0000, 16'(17 - j), 1'b0, 5'(16 - j));
    issue(2'b00, 16'hA5A5, 16'h0000, 1'b0, 5'd1);
    issue(2'b11, 16'h0000, 16'hA5A5, 1'b0, 5'd2);
    issue(2'b10, 16'h0F0F, 16'hA5A5, 1'b0, 5'd2);
    issue(2'b01, 16'h0000, 16'h0F0F, 1'b0, 5'd1);
    issue(2'b01, 16'h0000, 16'hA5A5, 1'b0, 5'd0);
    issue(2'b00, 16'h1111, 16'h0000, 1'b0, 5'd1);
    rsp_ready = 1'b0;
    issue(2'b00, 16'h7777, 16'h1111, 1'b0, 5'd2, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'h1111);
      chk("hold_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("release_idle", 32'(cmd_ready), 32'd1);
    issue(2'b01, 16'h0000, 16'h7777, 1'b0, 5'd1);
    issue(2'b01, 16'h0000, 16'h1111, 1'b0, 5'd0);
    issue(2'b00, 16'h3333, 16'h0000, 1'b0, 5'd1);
    s0 = strobes;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = 16'h5555;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    resetq = 1'b0;
    @(negedge clk);
    chk("rst_exec_we", 32'(stk_we), 32'd0);
    @(posedge clk);
    #1 resetq = 1'b1;
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_depth", 32'(depth), 32'd0);
    chk("rst_exec_ready", 32'(cmd_ready), 32'd1);
    chk("rst_exec_no_strobe", 32'(strobes), 32'(s0));
    issue(2'b00, 16'h4242, 16'h0000, 1'b0, 5'd1);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
